sprw_mac_lanes: RTL

- Parametrised successor to the fixed 4x8-bit sparrow SIMD datapath wrapper: LANES lanes of LW-bit operands, 2-stage pipelined multiply with lane-product, dot-product and dot-accumulate modes.
- Accumulator is internal and persistent; it is stalled by the global holdn like the rest of the sparrow pipeline.
- Sits beside sprw_module in the sparrow datapath and is fed from the same ra/rb register-read buses.

---
 rtl/sprw_mac_lanes.sv | 108 ++++++++++
 1 files changed

// File: rtl/sprw_mac_lanes.sv
// sprw_mac_lanes: LANES x LW-bit SIMD multiply with lane-product, dot and dot-accumulate modes
// Build option: define SPRW_MAC_SAT_EN to saturate the accumulator on overflow (default wraps).
// Ports:
//   clk, rstn (async active-low), holdn (0 freezes every register)
//   in_valid, ra, rb (lane i at [i*LW +: LW]), op (00 mul, 01 dot, 10 dot-acc, 11 clear), sgn
//   out_valid, result (lane products or extended dot sum), acc, ovf (sticky overflow)
module sprw_mac_lanes #(
    parameter int LANES = 4,
    parameter int LW    = 8,
    parameter int ACCW  = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    holdn,
    input  logic                    in_valid,
    input  logic [LANES*LW-1:0]     ra,
    input  logic [LANES*LW-1:0]     rb,
    input  logic [1:0]              op,
    input  logic                    sgn,
    output logic                    out_valid,
    output logic [LANES*2*LW-1:0]   result,
    output logic [ACCW-1:0]         acc,
    output logic                    ovf
);
    localparam int PW = 2 * LW;
    localparam int DW = PW + $clog2(LANES);
    localparam int RW = LANES * PW;

    logic [RW-1:0]   p_d, p_q;
    logic [1:0]      op_q;
    logic            sgn_q, v_q;
    logic            out_valid_d, out_valid_q;
    logic [RW-1:0]   result_d, result_q;
    logic [ACCW-1:0] acc_d, acc_q;
    logic            ovf_d, ovf_q;
    logic [DW-1:0]   dsum;
    logic [RW-1:0]   dext;
    logic [ACCW-1:0] dacc, sat, acc_new;
    logic [ACCW:0]   sum;
    logic            ovf_add;

    // Operands are extended to PW bits first, so one unsigned multiply
    // truncated to PW bits yields the correct signed or unsigned product.
    always_comb begin
        p_d = '0;
        for (int i = 0; i < LANES; i++)
            p_d[i*PW +: PW] = {{LW{sgn & ra[i*LW+LW-1]}}, ra[i*LW +: LW]}
                            * {{LW{sgn & rb[i*LW+LW-1]}}, rb[i*LW +: LW]};
    end

    always_comb begin
        dsum = '0;
        for (int i = 0; i < LANES; i++)
            dsum = dsum + {{(DW-PW){sgn_q & p_q[i*PW+PW-1]}}, p_q[i*PW +: PW]};
        dext = sgn_q ? RW'($signed(dsum)) : RW'(dsum);
        dacc = sgn_q ? ACCW'($signed(dsum)) : ACCW'(dsum);
        sum  = {1'b0, acc_q} + {1'b0, dacc};
        // Signed overflow: equal operand signs but result sign differs.
        // Unsigned: the addend is never negative, so only carry-out matters.
        ovf_add = sgn_q ? (acc_q[ACCW-1] == dacc[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1])
                        : sum[ACCW];
        sat = sgn_q ? {dacc[ACCW-1], {(ACCW-1){~dacc[ACCW-1]}}} : {ACCW{1'b1}};
`ifdef SPRW_MAC_SAT_EN
        acc_new = ovf_add ? sat : sum[ACCW-1:0];
`else
        acc_new = sum[ACCW-1:0];
`endif
    end

    always_comb begin
        out_valid_d = v_q;
        result_d    = result_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        if (v_q) begin
            result_d = op_q == 2'b00 ? p_q : op_q == 2'b11 ? '0 : dext;
            acc_d    = op_q == 2'b10 ? acc_new : op_q == 2'b11 ? '0 : acc_q;
            ovf_d    = op_q == 2'b10 ? (ovf_q | ovf_add) : op_q == 2'b11 ? 1'b0 : ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_q         <= '0;
            op_q        <= '0;
            sgn_q       <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (holdn) begin
            p_q         <= p_d;
            op_q        <= op;
            sgn_q       <= sgn;
            v_q         <= in_valid;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign acc       = acc_q;
    assign ovf       = ovf_q;
endmodule
